// File: rtl/norm2_host_loader.sv
// norm2_host_loader
//   Host-side driver for the norm2 kernel. Streams N signed samples into the
//   kernel array through its control port, optionally reads the array back
//   and compares checksums, pulses the kernel start, waits for done (with a
//   timeout) and returns the 64-bit sum of squares on a valid/ready channel.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   start           one-cycle request, honoured in IDLE only
//   busy            high in every state except IDLE
//   in_valid/in_ready/in_data      sample stream (ready only in LOAD)
//   res_valid/res_ready/res_data   result channel
//   res_status      [0] checksum mismatch, [1] kernel timeout
//   k_r_enable      kernel start pulse
//   k_control_arr   1 = host owns the array port, 0 = kernel owns it
//   k_arr_we/k_arr_addr/k_arr_wdata/k_arr_rdata  kernel array port
//   k_w_enable      kernel done
//   k_result        kernel result
//   k_init_i, k_init_acc  kernel initial values, tied to 0
module norm2_host_loader #(
  parameter int N         = 1000,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 27,
  parameter int RES_W     = 64,
  parameter int VERIFY_EN = 1,
  parameter int TIMEOUT   = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic [1:0]        res_status,
  output logic              k_r_enable,
  output logic              k_control_arr,
  output logic              k_arr_we,
  output logic [ADDR_W-1:0] k_arr_addr,
  output logic [DATA_W-1:0] k_arr_wdata,
  input  logic [DATA_W-1:0] k_arr_rdata,
  input  logic              k_w_enable,
  input  logic [RES_W-1:0]  k_result,
  output logic [63:0]       k_init_i,
  output logic [63:0]       k_init_acc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_START,
    S_WAIT,
    S_OUT
  } state_t;

  localparam int CNT_W = $clog2(N + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_N    = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  rcnt;
  logic [TMO_W-1:0]  tcnt;
  logic              rd_valid;
  logic [63:0]       wsum;
  logic [63:0]       rsum;
  logic [63:0]       rsum_next;
  logic [63:0]       in_ext;
  logic [63:0]       rd_ext;
  logic              verify_last;
  logic              timeout_hit;

  assign in_ext = {{(64-DATA_W){in_data[DATA_W-1]}}, in_data};
  assign rd_ext = {{(64-DATA_W){k_arr_rdata[DATA_W-1]}}, k_arr_rdata};

  // Read data lags the issued address by one cycle, so the final read is
  // folded in combinationally on the last VERIFY cycle.
  assign rsum_next   = rsum + (rd_valid ? rd_ext : 64'd0);
  assign verify_last = (state == S_VERIFY) && (rcnt == CNT_N);
  assign timeout_hit = (tcnt == TMO_LAST);

  assign busy       = (state != S_IDLE);
  assign k_init_i   = '0;
  assign k_init_acc = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    in_ready      = 1'b0;
    k_r_enable    = 1'b0;
    k_control_arr = 1'b1;
    k_arr_we      = 1'b0;
    k_arr_addr    = '0;
    k_arr_wdata   = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready    = 1'b1;
        k_arr_we    = in_valid;
        k_arr_addr  = ADDR_W'(cnt);
        k_arr_wdata = in_data;
        if (in_valid && (cnt == CNT_LAST)) begin
          state_next = (VERIFY_EN != 0) ? S_VERIFY : S_START;
        end
      end
      S_VERIFY: begin
        k_arr_addr = ADDR_W'(rcnt);
        if (verify_last) begin
          state_next = S_START;
        end
      end
      S_START: begin
        k_control_arr = 1'b0;
        k_r_enable    = 1'b1;
        state_next    = S_WAIT;
      end
      S_WAIT: begin
        k_control_arr = 1'b0;
        if (k_w_enable || timeout_hit) begin
          state_next = S_OUT;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      rcnt       <= '0;
      tcnt       <= '0;
      rd_valid   <= 1'b0;
      wsum       <= '0;
      rsum       <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_status <= '0;
    end else begin
      rd_valid <= (state == S_VERIFY) && (rcnt < CNT_N);
      if (state != S_VERIFY) begin
        rcnt <= '0;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt        <= '0;
            wsum       <= '0;
            rsum       <= '0;
            res_status <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            wsum <= wsum + in_ext;
            cnt  <= cnt + CNT_ONE;
          end
        end
        S_VERIFY: begin
          rsum <= rsum_next;
          rcnt <= rcnt + CNT_ONE;
          if (verify_last) begin
            res_status[0] <= (rsum_next != wsum);
          end
        end
        S_START: begin
          tcnt <= '0;
        end
        S_WAIT: begin
          tcnt <= tcnt + TMO_ONE;
          if (k_w_enable) begin
            res_data  <= k_result;
            res_valid <= 1'b1;
          end else if (timeout_hit) begin
            res_data      <= '0;
            res_status[1] <= 1'b1;
            res_valid     <= 1'b1;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
